// File: rtl/pe_sched_pkg.sv
// rtl/pe_sched_pkg.sv - shared types and packet field layout for the PE row scheduler
package pe_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_FILT,
        ST_FETCH,
        ST_SEND_ROW,
        ST_WAIT_PSUM,
        ST_FINISH
    } sched_state_e;

    localparam logic [2:0] PKT_FILTER = 3'b000;
    localparam logic [2:0] PKT_IFMAP  = 3'b001;

    localparam int SRC_MSB  = 34;
    localparam int SRC_LSB  = 31;
    localparam int DST_MSB  = 30;
    localparam int DST_LSB  = 27;
    localparam int TYPE_MSB = 26;
    localparam int TYPE_LSB = 24;
    localparam int PAY_MSB  = 23;
    localparam int PAY_LSB  = 0;

endpackage

// File: rtl/pe_pkt_fmt.sv
// rtl/pe_pkt_fmt.sv - packs {src, dest, type, payload} into a NoC packet
module pe_pkt_fmt
    import pe_sched_pkg::*;
#(
    parameter int WIDTH = 35
) (
    input  logic [3:0]       src_i,
    input  logic [3:0]       dest_i,
    input  logic [2:0]       type_i,
    input  logic [23:0]      payload_i,
    output logic [WIDTH-1:0] pkt_o
);

    always_comb begin
        pkt_o                    = '0;
        pkt_o[SRC_MSB:SRC_LSB]   = src_i;
        pkt_o[DST_MSB:DST_LSB]   = dest_i;
        pkt_o[TYPE_MSB:TYPE_LSB] = type_i;
        pkt_o[PAY_MSB:PAY_LSB]   = payload_i;
    end

endmodule

// File: rtl/pe_row_sched.sv
// rtl/pe_row_sched.sv - sequences one PE through filter load and per-timestep ifmap rows, gated by psum acks
module pe_row_sched
    import pe_sched_pkg::*;
#(
    parameter int         WIDTH    = 35,
    parameter logic [3:0] SRC_ADDR = 4'b0000,
    parameter logic [3:0] PE_ADDR  = 4'b1011,
    parameter int         ROWS     = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       num_ts,
    input  logic [23:0]      filter_data,
    output logic             row_req,
    output logic [3:0]       row_ts,
    output logic [3:0]       row_idx,
    input  logic             row_valid,
    input  logic [4:0]       row_data,
    output logic             pkt_valid,
    input  logic             pkt_ready,
    output logic [WIDTH-1:0] pkt_data,
    input  logic             psum_ack,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

    sched_state_e state_q, state_d;
    logic [3:0]   num_ts_q, num_ts_d;
    logic [23:0]  filt_q, filt_d;
    logic [3:0]   ts_cnt_q, ts_cnt_d;
    logic [3:0]   row_cnt_q, row_cnt_d;
    logic [4:0]   row_q, row_d;
    logic [1:0]   ack_cnt_q, ack_cnt_d;
    logic [1:0]   ack_need_q, ack_need_d;
    logic         err_q, err_d;
    logic [1:0]   need_now;
    logic [2:0]   pkt_type;
    logic [23:0]  pkt_payload;
    logic [WIDTH-1:0] pkt_w;

    // Last row of a timestep feeds only one S&T node; the others feed three.
    assign need_now = (row_cnt_q == LAST_ROW) ? 2'd1 : 2'd3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            num_ts_q   <= 4'd1;
            filt_q     <= '0;
            ts_cnt_q   <= '0;
            row_cnt_q  <= '0;
            row_q      <= '0;
            ack_cnt_q  <= '0;
            ack_need_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_ts_q   <= num_ts_d;
            filt_q     <= filt_d;
            ts_cnt_q   <= ts_cnt_d;
            row_cnt_q  <= row_cnt_d;
            row_q      <= row_d;
            ack_cnt_q  <= ack_cnt_d;
            ack_need_q <= ack_need_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        num_ts_d   = num_ts_q;
        filt_d     = filt_q;
        ts_cnt_d   = ts_cnt_q;
        row_cnt_d  = row_cnt_q;
        row_d      = row_q;
        ack_cnt_d  = ack_cnt_q;
        ack_need_d = ack_need_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (psum_ack) err_d = 1'b1;
                if (start) begin
                    num_ts_d  = (num_ts == 4'd0) ? 4'd1 : num_ts;
                    filt_d    = filter_data;
                    ts_cnt_d  = '0;
                    row_cnt_d = '0;
                    ack_cnt_d = '0;
                    err_d     = 1'b0;
                    state_d   = ST_SEND_FILT;
                end
            end
            ST_SEND_FILT: begin
                if (psum_ack) err_d = 1'b1;
                if (pkt_ready) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (psum_ack) err_d = 1'b1;
                if (row_valid) begin
                    row_d   = row_data;
                    state_d = ST_SEND_ROW;
                end
            end
            ST_SEND_ROW: begin
                if (psum_ack) begin
                    if (ack_cnt_q == need_now) err_d = 1'b1;
                    else ack_cnt_d = ack_cnt_q + 2'd1;
                end
                if (pkt_ready) begin
                    ack_need_d = need_now;
                    state_d    = ST_WAIT_PSUM;
                end
            end
            ST_WAIT_PSUM: begin
                if (ack_cnt_q == ack_need_q) begin
                    ack_cnt_d = '0;
                    if (psum_ack) err_d = 1'b1;
                    if (row_cnt_q < LAST_ROW) begin
                        row_cnt_d = row_cnt_q + 4'd1;
                        state_d   = ST_FETCH;
                    end else if (ts_cnt_q < num_ts_q - 4'd1) begin
                        row_cnt_d = '0;
                        ts_cnt_d  = ts_cnt_q + 4'd1;
                        state_d   = ST_FETCH;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end else if (psum_ack) begin
                    ack_cnt_d = ack_cnt_q + 2'd1;
                end
            end
            ST_FINISH: begin
                if (psum_ack) err_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pkt_valid   = (state_q == ST_SEND_FILT) || (state_q == ST_SEND_ROW);
    assign pkt_type    = (state_q == ST_SEND_ROW) ? PKT_IFMAP : PKT_FILTER;
    assign pkt_payload = (state_q == ST_SEND_ROW) ? {19'b0, row_q} : filt_q;

    pe_pkt_fmt #(.WIDTH(WIDTH)) u_fmt (
        .src_i     (SRC_ADDR),
        .dest_i    (PE_ADDR),
        .type_i    (pkt_type),
        .payload_i (pkt_payload),
        .pkt_o     (pkt_w)
    );

    assign pkt_data = pkt_valid ? pkt_w : '0;
    assign row_req  = (state_q == ST_FETCH);
    assign row_ts   = ts_cnt_q;
    assign row_idx  = row_cnt_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FINISH);
    assign err      = err_q;

endmodule

// File: tb/tb_pe_row_sched.sv
// tb/tb_pe_row_sched.sv - directed self-checking bench for pe_row_sched
module tb_pe_row_sched;

    localparam int ROWS = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  num_ts = '0;
    logic [23:0] filter_data = '0;
    logic        row_req;
    logic [3:0]  row_ts;
    logic [3:0]  row_idx;
    logic        row_valid = 1'b0;
    logic [4:0]  row_data = '0;
    logic        pkt_valid;
    logic        pkt_ready = 1'b1;
    logic [34:0] pkt_data;
    logic        psum_ack = 1'b0;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int hs_filt = 0;
    int hs_row = 0;
    int n_acks = 0;

    always #5 clk = ~clk;

    pe_row_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_ts      (num_ts),
        .filter_data (filter_data),
        .row_req     (row_req),
        .row_ts      (row_ts),
        .row_idx     (row_idx),
        .row_valid   (row_valid),
        .row_data    (row_data),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .pkt_data    (pkt_data),
        .psum_ack    (psum_ack),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always @(posedge clk) begin
        if (rst_n) begin
            if (pkt_valid && pkt_ready) begin
                if (pkt_data[26:24] == 3'b000) hs_filt++;
                else hs_row++;
            end
            if (psum_ack) n_acks++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] row_pkt(input logic [4:0] d);
        return {4'h0, 4'hB, 3'b001, 19'b0, d};
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 64'(pkt_valid), 64'd0);
        check({tag, "_data"},  64'(pkt_data),  64'd0);
        check({tag, "_req"},   64'(row_req),   64'd0);
        check({tag, "_busy"},  64'(busy),      64'd0);
        check({tag, "_done"},  64'(done),      64'd0);
        check({tag, "_err"},   64'(err),       64'd0);
        check({tag, "_ts"},    64'(row_ts),    64'd0);
        check({tag, "_idx"},   64'(row_idx),   64'd0);
    endtask

    task automatic send_acks(input int k);
        for (int i = 0; i < k; i++) begin
            psum_ack = 1'b1;
            @(negedge clk);
        end
        psum_ack = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (row_req) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        check("row_req_timeout", 64'd0, 64'd1);
    endtask

    task automatic run(input logic [3:0] nts, input logic [23:0] filt, input int stall_row,
                       input int hold_row, input int extra_row, input int abort_row,
                       input logic exp_err);
        int  n_ts;
        int  need;
        bit  ok;
        logic [4:0] rd;
        n_ts = (nts == 4'd0) ? 1 : int'(nts);
        hs_filt = 0;
        hs_row = 0;
        n_acks = 0;
        @(negedge clk);
        start = 1'b1;
        num_ts = nts;
        filter_data = filt;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_err_clr", 64'(err), 64'd0);
        check("filt_valid", 64'(pkt_valid), 64'd1);
        check("filt_data", 64'(pkt_data), 64'({4'h0, 4'hB, 3'b000, filt}));
        for (int t = 0; t < n_ts; t++) begin
            for (int r = 0; r < ROWS; r++) begin
                wait_req(ok);
                if (!ok) return;
                check("row_ts", 64'(row_ts), 64'(t));
                check("row_idx", 64'(row_idx), 64'(r));
                rd = 5'(r * 7 + t * 3 + 1);
                row_valid = 1'b1;
                row_data = rd;
                if (r == stall_row) pkt_ready = 1'b0;
                @(negedge clk);
                row_valid = 1'b0;
                row_data = '0;
                check("row_valid", 64'(pkt_valid), 64'd1);
                check("row_data", 64'(pkt_data), 64'(row_pkt(rd)));
                if (r == stall_row) begin
                    repeat (5) begin
                        @(negedge clk);
                        check("stall_valid", 64'(pkt_valid), 64'd1);
                        check("stall_data", 64'(pkt_data), 64'(row_pkt(rd)));
                    end
                    pkt_ready = 1'b1;
                end
                @(negedge clk);
                need = (r == ROWS - 1) ? 1 : 3;
                if (r == hold_row && t == 0) begin
                    send_acks(2);
                    repeat (4) begin
                        @(negedge clk);
                        check("hold_req", 64'(row_req), 64'd0);
                        check("hold_busy", 64'(busy), 64'd1);
                    end
                    send_acks(1);
                end else if (r == abort_row && t == 0) begin
                    send_acks(1);
                    rst_n = 1'b0;
                    @(negedge clk);
                    check_idle_outputs("abort");
                    rst_n = 1'b1;
                    @(negedge clk);
                    return;
                end else begin
                    send_acks(need);
                end
                if (r == extra_row && t == 0) begin
                    send_acks(1);
                    check("extra_ack_err", 64'(err), 64'd1);
                end
            end
        end
        for (int i = 0; i < 10; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check("done_pulse", 64'(done), 64'd1);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("n_filt_pkts", 64'(hs_filt), 64'd1);
        check("n_row_pkts", 64'(hs_row), 64'(n_ts * ROWS));
        check("n_acks", 64'(n_acks), 64'(n_ts * ((ROWS - 1) * 3 + 1) + ((extra_row >= 0) ? 1 : 0)));
        check("end_err", 64'(err), 64'(exp_err));
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run(4'd1, 24'h030201, -1, -1, -1, -1, 1'b0);
        run(4'd2, 24'hA5C3E7, -1, -1, -1, -1, 1'b0);
        run(4'd1, 24'h112233, 4, -1, -1, -1, 1'b0);
        run(4'd1, 24'h445566, -1, 2, -1, -1, 1'b0);

        psum_ack = 1'b1;
        @(negedge clk);
        psum_ack = 1'b0;
        check("stray_ack_err", 64'(err), 64'd1);
        repeat (3) @(negedge clk);
        check("stray_err_sticky", 64'(err), 64'd1);
        run(4'd1, 24'h778899, -1, -1, 0, -1, 1'b1);
        run(4'd0, 24'h0A0B0C, -1, -1, -1, -1, 1'b0);

        run(4'd1, 24'hDDEEFF, -1, -1, -1, 5, 1'b0);
        run(4'd1, 24'h030201, -1, -1, -1, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
